dm_arbiter: RTL
===============

# dm_arbiter

Two-port arbiter and access sequencer for the single-port data memory. It shares the memory between the pipeline MEM stage (port 0) and the external loader/debug port (port 1), with round-robin arbitration and a req/ack handshake. It also merges partial stores with byte enables using read-modify-write. It sits between both requesters and the memory instance, and it is the only driver of the memory's write-enable, address and write-data pins.

## Interface
Parameters:
- ADDR_W, 10, word-address width of the memory (depth 2^ADDR_W words)
- DATA_W, 32, word width; must be 32 (byte enables are 4 bits)

Ports:
- Clock  in  1  clock
- Reset  in  1  reset Reset, synchronous, active-high; clock Clock
- p0_req  in  1  port 0 request; held until p0_ack
- p0_we  in  1  port 0 write (1) / read (0)
- p0_addr  in  32  port 0 byte address
- p0_be  in  4  port 0 byte enables (bit i = byte i, little-endian); ignored on reads
- p0_wdata  in  32  port 0 store data, lane-aligned
- p0_pc  in  32  PC of the port 0 store instruction, used for trace only
- p0_ack  out  1  one-cycle completion pulse
- p0_rdata  out  32  registered read word; valid while p0_ack=1
- p1_req, p1_we, p1_addr, p1_be, p1_wdata, p1_ack, p1_rdata: same as port 0, without a pc input
- dm_we  out  1  memory write enable
- dm_addr  out  ADDR_W  memory word address
- dm_wdata  out  32  merged write word
- dm_rdata  in  32  memory read data (combinational read of dm_addr)

## Operation
- FSM states: IDLE, ACK. Reset state is IDLE.
- IDLE with no eligible request:
  - dm_we=0, dm_addr=0, dm_wdata=0, and the FSM stays in IDLE.
- IDLE with one or more eligible requests:
  - Select the winner, drive dm_addr = addr[ADDR_W+1:2] from it, and go to ACK.
  - Address bits above ADDR_W+1 are ignored (address wraps modulo the memory size). addr[1:0] is ignored.
  - Write: dm_wdata byte i = be[i] ? wdata byte i : dm_rdata byte i. dm_we=1 if be≠0. be=0 performs no write but still acks.
  - Read: dm_we=0. dm_rdata is captured into the winner's rdata register at the clock edge.
  - On writes, the rdata register captures the pre-write memory word.
- ACK:
  - The winner's ack=1 and dm_we=0. The FSM always returns to IDLE next.
  - A port is not eligible in its own ack cycle, so its next request is sampled no earlier than the following cycle.
- Arbitration is round-robin on the last_grant register:
  - If both ports request, the port that was not last granted wins.
  - If only one port requests, it wins regardless of last_grant.
  - last_grant resets to 1, so port 0 wins the first tie.
- Reset values: p0_ack=p1_ack=0, p0_rdata=p1_rdata=0, dm_we=0, dm_addr=0, dm_wdata=0, last_grant=1.
- Reset dominates everything:
  - A Reset in the access cycle suppresses dm_we in that cycle.
  - A Reset in the ACK cycle drops the pending ack. The requester must re-issue the request.

## Timing
- Latency: request accepted in cycle N (IDLE) → ack in cycle N+1. The memory write commits at the edge ending cycle N.
- Throughput: at most one access per 2 cycles in total across both ports.
- Worst-case wait under contention: 2 cycles beyond the other port's single access (no starvation).
- The request, we, addr, be and wdata inputs must be stable from assertion of req until ack. Any change before ack is a protocol violation with undefined result.
- The rdata outputs hold their value until the same port's next access completes.

## Configuration
- DM_ARB_TRACE_EN defined: every committed write (dm_we=1) prints $display("%d@%h: *%h <= %h", $time, pc, byte_addr, merged_word).
  - pc is p0_pc for port 0 and 32'h0 for port 1.
  - byte_addr is the requester's full 32-bit address with bits [1:0] forced to 0.
- DM_ARB_TRACE_EN undefined: no display statements. The p0_pc input remains present but unused.

## Structure
- Package dm_arb_pkg holds:
  - the state enum (IDLE, ACK)
  - the port-id constants PORT0=1'b0 and PORT1=1'b1
  - the default ADDR_W
- Sub-module dm_byte_merge (combinational): inputs old word, new word and be; output the merged word. It is instantiated once, on the winner's signals.

## Test plan
- Reset, then p0 write addr 0x0000_0010, be=4'hF, wdata 0xDEADBEEF → dm_we=1 with dm_addr=4 in the access cycle; p0_ack the next cycle; a later p0 read of 0x10 returns 0xDEADBEEF.
- Word 4 = 0xDEADBEEF, then p1 write be=4'b0010, wdata 0x0000_5A00 → dm_wdata=0xDEAD5AEF, p1_rdata=0xDEADBEEF on ack.
- p0 and p1 both request reads continuously from reset → grants alternate p0, p1, p0, p1; each ack is spaced 2 cycles apart.
- p0 address 0x0000_1008 with ADDR_W=10 → dm_addr=2 (wrap).
- Reset asserted during the ACK cycle of a p1 read → p1_ack stays 0, state IDLE, p1_rdata=0. The re-issued request is acked normally.
- DM_ARB_TRACE_EN defined, p0 write with pc 0x3000, addr 0x14, data 0x1 → exactly one line containing "@00003000: *00000014 <= 00000001".

Source files
------------

// File: rtl/dm_arb_pkg.sv
// ============================================================================
// Module      : dm_arb_pkg
// Description : Shared types and constants for the data-memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dm_arb_pkg;

  localparam int DEFAULT_ADDR_W = 10;
  localparam int WORD_W         = 32;
  localparam int BE_W           = WORD_W / 8;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    ACK  = 1'b1
  } state_t;

endpackage

`default_nettype wire

// File: rtl/dm_arbiter_if.sv
// ============================================================================
// Module      : dm_arbiter_if
// Description : Requester-side and memory-side bus of the data-memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface dm_arbiter_if
  import dm_arb_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W
);

  // port 0: pipeline MEM stage
  logic              p0_req;
  logic              p0_we;
  logic [31:0]       p0_addr;
  logic [BE_W-1:0]   p0_be;
  logic [WORD_W-1:0] p0_wdata;
  logic [31:0]       p0_pc;
  logic              p0_ack;
  logic [WORD_W-1:0] p0_rdata;

  // port 1: loader / debug
  logic              p1_req;
  logic              p1_we;
  logic [31:0]       p1_addr;
  logic [BE_W-1:0]   p1_be;
  logic [WORD_W-1:0] p1_wdata;
  logic              p1_ack;
  logic [WORD_W-1:0] p1_rdata;

  // memory pins
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [WORD_W-1:0] dm_wdata;
  logic [WORD_W-1:0] dm_rdata;

  modport slave (
    input  p0_req, p0_we, p0_addr, p0_be, p0_wdata, p0_pc,
    output p0_ack, p0_rdata,
    input  p1_req, p1_we, p1_addr, p1_be, p1_wdata,
    output p1_ack, p1_rdata,
    output dm_we, dm_addr, dm_wdata,
    input  dm_rdata
  );

  modport master (
    output p0_req, p0_we, p0_addr, p0_be, p0_wdata, p0_pc,
    input  p0_ack, p0_rdata,
    output p1_req, p1_we, p1_addr, p1_be, p1_wdata,
    input  p1_ack, p1_rdata,
    input  dm_we, dm_addr, dm_wdata,
    output dm_rdata
  );

endinterface

`default_nettype wire

// File: rtl/dm_byte_merge.sv
// ============================================================================
// Module      : dm_byte_merge
// Description : Combinational byte-lane merge of a new word into an old word.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dm_byte_merge #(
  parameter int DATA_W = 32
) (
  input  wire logic [DATA_W-1:0]   i_old_word,
  input  wire logic [DATA_W-1:0]   i_new_word,
  input  wire logic [DATA_W/8-1:0] i_be,
  output logic      [DATA_W-1:0]   o_merged_word
);

  for (genvar i = 0; i < DATA_W / 8; i++) begin : g_lane
    assign o_merged_word[8*i +: 8] = i_be[i] ? i_new_word[8*i +: 8] : i_old_word[8*i +: 8];
  end

endmodule

`default_nettype wire

// File: rtl/dm_arbiter.sv
// ============================================================================
// Module      : dm_arbiter
// Description : Round-robin two-port arbiter and read-modify-write sequencer
//               for the single-port data memory. Define DM_ARB_TRACE_EN to
//               print a trace line for every committed write.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dm_arbiter
  import dm_arb_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter int DATA_W = WORD_W
) (
  input wire logic    Clock,
  input wire logic    Reset,
  dm_arbiter_if.slave bus
);

  state_t            state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic              p0_ack_q, p0_ack_d;
  logic              p1_ack_q, p1_ack_d;
  logic [DATA_W-1:0] p0_rdata_q, p0_rdata_d;
  logic [DATA_W-1:0] p1_rdata_q, p1_rdata_d;

  logic              access_valid;
  logic              winner;
  logic              win_we;
  logic [31:0]       win_addr;
  logic [BE_W-1:0]   win_be;
  logic [DATA_W-1:0] win_wdata;
  logic [DATA_W-1:0] merged_word;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;

  // Only IDLE accepts requests, so a port's own ack cycle is never a grant cycle.
  always_comb begin
    access_valid = (state_q == IDLE) && (bus.p0_req || bus.p1_req);
    if (bus.p0_req && bus.p1_req) begin
      winner = ~last_grant_q;
    end else if (bus.p0_req) begin
      winner = PORT0;
    end else begin
      winner = PORT1;
    end
  end

  always_comb begin
    if (winner == PORT0) begin
      win_we    = bus.p0_we;
      win_addr  = bus.p0_addr;
      win_be    = bus.p0_be;
      win_wdata = bus.p0_wdata;
    end else begin
      win_we    = bus.p1_we;
      win_addr  = bus.p1_addr;
      win_be    = bus.p1_be;
      win_wdata = bus.p1_wdata;
    end
  end

  dm_byte_merge #(
    .DATA_W (DATA_W)
  ) u_merge (
    .i_old_word    (bus.dm_rdata),
    .i_new_word    (win_wdata),
    .i_be          (win_be),
    .o_merged_word (merged_word)
  );

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (access_valid && !Reset) begin
      mem_addr = win_addr[ADDR_W+1:2];
      if (win_we) begin
        mem_wdata = merged_word;
        mem_we    = |win_be;
      end
    end
  end

  assign bus.dm_we    = mem_we;
  assign bus.dm_addr  = mem_addr;
  assign bus.dm_wdata = mem_wdata;

  // The rdata register of the winner always takes the pre-write memory word.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    p0_ack_d     = 1'b0;
    p1_ack_d     = 1'b0;
    p0_rdata_d   = p0_rdata_q;
    p1_rdata_d   = p1_rdata_q;
    case (state_q)
      IDLE: begin
        if (access_valid) begin
          state_d      = ACK;
          last_grant_d = winner;
          if (winner == PORT0) begin
            p0_ack_d   = 1'b1;
            p0_rdata_d = bus.dm_rdata;
          end else begin
            p1_ack_d   = 1'b1;
            p1_rdata_d = bus.dm_rdata;
          end
        end
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q      <= IDLE;
      last_grant_q <= PORT1;
      p0_ack_q     <= 1'b0;
      p1_ack_q     <= 1'b0;
      p0_rdata_q   <= '0;
      p1_rdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      p0_ack_q     <= p0_ack_d;
      p1_ack_q     <= p1_ack_d;
      p0_rdata_q   <= p0_rdata_d;
      p1_rdata_q   <= p1_rdata_d;
    end
  end

  // Reset in the ack cycle withdraws the ack immediately; the requester retries.
  assign bus.p0_ack   = p0_ack_q && !Reset;
  assign bus.p1_ack   = p1_ack_q && !Reset;
  assign bus.p0_rdata = p0_rdata_q;
  assign bus.p1_rdata = p1_rdata_q;

  logic unused_inputs;
  assign unused_inputs = ^{bus.p0_pc, win_addr[1:0], win_addr[31:ADDR_W+2]};

`ifdef DM_ARB_TRACE_EN
  logic [31:0] trace_pc;
  assign trace_pc = (winner == PORT0) ? bus.p0_pc : 32'h0;

  always_ff @(posedge Clock) begin
    if (mem_we) begin
      $display("%d@%h: *%h <= %h", $time, trace_pc, {win_addr[31:2], 2'b00}, merged_word);
    end
  end
`endif

endmodule

`default_nettype wire
